lcd_display_ctrl: RTL and testbench

Parametrised multi-digit display and alarm controller for the alarm-clock datapath. It sits between the time/alarm registers, the key buffer and the LCD panel. It selects one of three N-digit sources and encodes each BCD digit as an LCD character. It blinks digits while a new time is being entered, and runs a timed, acknowledgeable alarm state machine. Outputs are registered, unlike the previous single-digit combinational driver.

---
 rtl/lcd_pkg.sv | 16 +
 rtl/lcd_digit_encode.sv | 10 +
 rtl/lcd_display_ctrl.sv | 70 +++++++
 tb/tb_lcd_display_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: LCD character codes and alarm FSM state encodings shared by the display controller
package lcd_pkg;
  localparam logic [7:0] LCD_ZERO  = 8'h30;
  localparam logic [7:0] LCD_ONE   = 8'h31;
  localparam logic [7:0] LCD_TWO   = 8'h32;
  localparam logic [7:0] LCD_THREE = 8'h33;
  localparam logic [7:0] LCD_FOUR  = 8'h34;
  localparam logic [7:0] LCD_FIVE  = 8'h35;
  localparam logic [7:0] LCD_SIX   = 8'h36;
  localparam logic [7:0] LCD_SEVEN = 8'h37;
  localparam logic [7:0] LCD_EIGHT = 8'h38;
  localparam logic [7:0] LCD_NINE  = 8'h39;
  localparam logic [7:0] LCD_ERROR = 8'h3A;
  localparam logic [7:0] LCD_BLANK = 8'h20;
  typedef enum logic [1:0] {ALM_IDLE, ALM_RING, ALM_HOLD} alm_state_t;
endpackage

// File: rtl/lcd_digit_encode.sv
// lcd_digit_encode: BCD digit + blank flag in, LCD char out (0-9 -> '0'-'9', 10-15 -> error char)
module lcd_digit_encode
  import lcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] char_code
);
  assign char_code = blank ? LCD_BLANK : digit > 4'd9 ? LCD_ERROR : LCD_ZERO + {4'd0, digit};
endmodule

// File: rtl/lcd_display_ctrl.sv
// lcd_display_ctrl: registered N-digit LCD source mux/encoder with entry blink, plus timed acknowledgeable alarm FSM (clock/reset, time inputs, selects, alarm controls in; display_time, sound_alarm, alarm_ringing out)
module lcd_display_ctrl
  import lcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int ALARM_SECS = 60,
  parameter bit BLINK_EN   = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    one_second,
  input  logic [4*NUM_DIGITS-1:0] key_time,
  input  logic [4*NUM_DIGITS-1:0] alarm_time,
  input  logic [4*NUM_DIGITS-1:0] current_time,
  input  logic                    show_new_time,
  input  logic                    show_alarm,
  input  logic                    alarm_enable,
  input  logic                    alarm_off,
  output logic [8*NUM_DIGITS-1:0] display_time,
  output logic                    sound_alarm,
  output logic                    alarm_ringing
);
  localparam int CW = $clog2(ALARM_SECS + 1);
  localparam logic [CW-1:0] LAST = CW'(ALARM_SECS - 1);
  logic [4*NUM_DIGITS-1:0] src;
  logic [8*NUM_DIGITS-1:0] chars;
  logic blink_phase, blink_next, blank, match, timeout, ring_q;
  logic [CW-1:0] secs;
  alm_state_t state, state_n;
  // blink_next feeds the display register so a tick's blank appears one clock after it
  always_comb begin
    src        = show_new_time ? key_time : show_alarm ? alarm_time : current_time;
    blink_next = show_new_time && (blink_phase ^ one_second);
    blank      = BLINK_EN && blink_next;
    match      = current_time == alarm_time;
    timeout    = one_second && secs == LAST;
    state_n    = state;
    case (state)
      ALM_IDLE: state_n = match && alarm_enable ? ALM_RING : ALM_IDLE;
      ALM_RING: state_n = alarm_off || !alarm_enable || timeout ? ALM_HOLD : ALM_RING;
      ALM_HOLD: state_n = match ? ALM_HOLD : ALM_IDLE;
      default:  state_n = ALM_IDLE;
    endcase
  end
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_enc
    lcd_digit_encode u_enc (
      .digit    (src[4*i +: 4]),
      .blank    (blank),
      .char_code(chars[8*i +: 8])
    );
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ALM_IDLE;
      secs         <= '0;
      blink_phase  <= 1'b0;
      ring_q       <= 1'b0;
      display_time <= {NUM_DIGITS{LCD_ZERO}};
    end else begin
      state        <= state_n;
      blink_phase  <= blink_next;
      ring_q       <= state_n == ALM_RING;
      display_time <= chars;
      if (state == ALM_IDLE) secs <= '0;
      else if (state == ALM_RING && one_second && secs != LAST) secs <= secs + CW'(1);
    end
  end
  assign sound_alarm   = ring_q;
  assign alarm_ringing = ring_q;
endmodule

// File: tb/tb_lcd_display_ctrl.sv
// tb_lcd_display_ctrl: directed + randomized bench against a behavioural display/alarm model
module tb_lcd_display_ctrl;
  localparam int S = 3;
  logic clock = 0, reset = 1, one_second = 0;
  logic [15:0] key_time = 16'h0915, alarm_time = 16'h0630, current_time = 16'h1234;
  logic show_new_time = 0, show_alarm = 0, alarm_enable = 0, alarm_off = 0;
  logic [31:0] display_time;
  logic sound_alarm, alarm_ringing;
  int checks = 0, failures = 0;
  lcd_display_ctrl #(.NUM_DIGITS(4), .ALARM_SECS(S), .BLINK_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .one_second(one_second), .key_time(key_time),
    .alarm_time(alarm_time), .current_time(current_time), .show_new_time(show_new_time),
    .show_alarm(show_alarm), .alarm_enable(alarm_enable), .alarm_off(alarm_off),
    .display_time(display_time), .sound_alarm(sound_alarm), .alarm_ringing(alarm_ringing)
  );
  always #5 clock = ~clock;
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  // model: ringing while fewer than S counted ticks and no acknowledge; after stopping, blocked until mismatch
  bit m_ring, m_blocked, m_blink;
  int m_ticks;
  logic [31:0] exp_disp;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_ring = 0; m_blocked = 0; m_blink = 0; m_ticks = 0; exp_disp = 32'h30303030;
    end else begin
      logic [15:0] s;
      if (m_ring) begin
        if (alarm_off || !alarm_enable) begin m_ring = 0; m_blocked = 1; end
        else if (one_second) begin
          m_ticks++;
          if (m_ticks >= S) begin m_ring = 0; m_blocked = 1; end
        end
      end else if (m_blocked) begin
        if (current_time != alarm_time) m_blocked = 0;
      end else if (current_time == alarm_time && alarm_enable) begin
        m_ring = 1; m_ticks = 0;
      end
      m_blink = show_new_time ? (one_second ? !m_blink : m_blink) : 0;
      s = show_new_time ? key_time : show_alarm ? alarm_time : current_time;
      for (int i = 0; i < 4; i++) begin
        int d;
        d = (s >> (4 * i)) & 15;
        exp_disp[8*i +: 8] = m_blink ? 8'd32 : d < 10 ? 8'(48 + d) : 8'd58;
      end
    end
  end
  always @(negedge clock) begin
    check("model_display", display_time, exp_disp);
    check("model_sound", {31'd0, sound_alarm}, {31'd0, m_ring});
    check("model_ringing", {31'd0, alarm_ringing}, {31'd0, m_ring});
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic tick();
    one_second = 1; cyc(1); one_second = 0;
  endtask
  initial begin
    cyc(2);
    check("reset_display", display_time, 32'h30303030);
    check("reset_sound", {31'd0, sound_alarm}, 32'd0);
    reset = 0; cyc(1);
    check("current_display", display_time, 32'h31323334);
    show_alarm = 1; cyc(1);
    check("alarm_display", display_time, 32'h30363330);
    show_new_time = 1; cyc(1);
    check("key_priority", display_time, 32'h30393135);
    key_time = 16'h0A0F; cyc(1);
    check("error_char", display_time, 32'h303A303A);
    key_time = 16'h0915; tick();
    check("blink_on", display_time, 32'h20202020);
    cyc(1);
    check("blink_hold", display_time, 32'h20202020);
    tick();
    check("blink_off", display_time, 32'h30393135);
    tick();
    check("blink_on2", display_time, 32'h20202020);
    show_new_time = 0; cyc(1);
    check("blink_clear", display_time, 32'h30363330);
    show_alarm = 0;
    alarm_enable = 1; current_time = 16'h0630; cyc(1);
    check("alarm_start", {31'd0, sound_alarm}, 32'd1);
    tick(); tick();
    check("alarm_after2", {31'd0, sound_alarm}, 32'd1);
    tick();
    check("auto_stop", {31'd0, sound_alarm}, 32'd0);
    cyc(4);
    check("hold_no_retrigger", {31'd0, sound_alarm}, 32'd0);
    current_time = 16'h0631; cyc(1);
    current_time = 16'h0630; cyc(1);
    check("rearm", {31'd0, sound_alarm}, 32'd1);
    alarm_off = 1; cyc(1); alarm_off = 0;
    check("ack_stop", {31'd0, sound_alarm}, 32'd0);
    cyc(2);
    check("ack_hold", {31'd0, alarm_ringing}, 32'd0);
    current_time = 16'h0631; cyc(1);
    current_time = 16'h0630; cyc(1);
    check("rearm2", {31'd0, sound_alarm}, 32'd1);
    alarm_enable = 0; cyc(1); alarm_enable = 1;
    check("disarm_stop", {31'd0, sound_alarm}, 32'd0);
    current_time = 16'h0631; cyc(1);
    current_time = 16'h0630; cyc(1);
    check("rearm3", {31'd0, sound_alarm}, 32'd1);
    #2 reset = 1;
    #1 check("async_reset_sound", {31'd0, sound_alarm}, 32'd0);
    check("async_reset_ringing", {31'd0, alarm_ringing}, 32'd0);
    cyc(1); reset = 0; cyc(1);
    check("ring_after_reset", {31'd0, sound_alarm}, 32'd1);
    tick(); tick();
    one_second = 1; alarm_off = 1; cyc(1); one_second = 0; alarm_off = 0;
    check("coincident_stop", {31'd0, sound_alarm}, 32'd0);
    cyc(3);
    check("coincident_hold", {31'd0, sound_alarm}, 32'd0);
    for (int n = 0; n < 1500; n++) begin
      int r;
      one_second = $urandom_range(3) == 0;
      alarm_off = $urandom_range(15) == 0;
      alarm_enable = $urandom_range(7) != 0;
      if ($urandom_range(7) == 0) show_new_time = !show_new_time;
      if ($urandom_range(7) == 0) show_alarm = !show_alarm;
      if ($urandom_range(4) == 0) key_time = 16'($urandom);
      r = $urandom_range(5);
      if (r == 1 || r == 2) current_time = alarm_time;
      else if (r == 3) current_time = alarm_time + 16'd1;
      else if (r == 4) current_time = 16'($urandom);
      cyc(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
